// File: rtl/uart_v2_pkg.sv
// uart_v2_pkg: shared state encoding and timing constants for the uart_v2
// receiver and transmitter. The 8E1 variant of the receiver is selected
// with the macro UART_RX_PARITY_EN.
package uart_v2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int UART_OVERSAMPLE = 4;
    localparam int UART_MID_TICK   = 2;

    // Even parity over one data byte: the parity bit that makes the total count of ones even.
    function automatic logic uart_even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_v2_rx_if.sv
// uart_v2_rx_if: serial input, sample strobe and MCU-side holding-register
// handshake of the uart_v2 receiver.
interface uart_v2_rx_if;

    logic       sample_en;
    logic       rx_line;
    logic       rx_ack;
    logic [7:0] parallel_out;
    logic       rx_ready;
    logic       framing_err;
    logic       overrun;
    logic       rx_busy;

    // MCU / line side
    modport master (
        output sample_en, rx_line, rx_ack,
        input  parallel_out, rx_ready, framing_err, overrun, rx_busy
    );

    // receiver side
    modport slave (
        input  sample_en, rx_line, rx_ack,
        output parallel_out, rx_ready, framing_err, overrun, rx_busy
    );

endinterface

// File: rtl/uart_v2_rx_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level, with a
// selectable reset value so an idle-high line does not look like a start bit.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage resynchronisation of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_v2_rx.sv
// uart_v2_rx: 8N1 serial receiver, 4x oversampled via the sample_en strobe,
// with a single holding register and ready/ack handshake.
// Define UART_RX_PARITY_EN for 8E1 frames; a parity mismatch is reported
// through framing_err.
module uart_v2_rx
    import uart_v2_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic        sysclk,
    input  logic        sysreset,
    uart_v2_rx_if.slave bus
);

    localparam logic [1:0] LAST_TICK_C = 2'(OVERSAMPLE - 1);
    localparam logic [1:0] MID_TICK_C  = 2'(UART_MID_TICK - 1);

    logic        rxs_s;
    uart_state_e state_r, state_nx_s;
    logic [1:0]  tcnt_r, tcnt_nx_s;
    logic [2:0]  bcnt_r, bcnt_nx_s;
    logic [7:0]  shift_r, shift_nx_s;
    logic        deliver_s;
    logic        frame_err_s;
    logic [7:0]  parallel_out_r;
    logic        rx_ready_r;
    logic        framing_err_r;
    logic        overrun_r;
    logic        rx_busy_r;
`ifdef UART_RX_PARITY_EN
    logic        par_err_r, par_err_nx_s;
`endif

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (sysclk),
        .rst_n (sysreset),
        .d     (bus.rx_line),
        .q     (rxs_s)
    );

    // Frame state machine: next state, counters and shift register, all advanced only on sample_en.
    always_comb begin
        state_nx_s  = state_r;
        tcnt_nx_s   = tcnt_r;
        bcnt_nx_s   = bcnt_r;
        shift_nx_s  = shift_r;
        deliver_s   = 1'b0;
        frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_nx_s = par_err_r;
`endif
        if (bus.sample_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rxs_s) begin
                        state_nx_s = ST_START;
                        tcnt_nx_s  = 2'd0;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tcnt_r == MID_TICK_C) begin
                        // Mid-start: a high line here was only a glitch.
                        if (rxs_s) begin
                            state_nx_s = ST_IDLE;
                        end else begin
                            state_nx_s = ST_DATA;
                            tcnt_nx_s  = 2'd0;
                            bcnt_nx_s  = 3'd0;
                        end
                    end else begin
                        tcnt_nx_s = tcnt_r + 2'd1;
                    end
                end
                ST_DATA: begin
                    if (tcnt_r == LAST_TICK_C) begin
                        shift_nx_s = {rxs_s, shift_r[7:1]};
                        tcnt_nx_s  = 2'd0;
                        bcnt_nx_s  = bcnt_r + 3'd1;
                        if (bcnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nx_s = ST_PARITY;
`else
                            state_nx_s = ST_STOP;
`endif
                        end else begin
                            state_nx_s = ST_DATA;
                        end
                    end else begin
                        tcnt_nx_s = tcnt_r + 2'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tcnt_r == LAST_TICK_C) begin
                        par_err_nx_s = rxs_s ^ uart_even_parity(shift_r);
                        tcnt_nx_s    = 2'd0;
                        state_nx_s   = ST_STOP;
                    end else begin
                        tcnt_nx_s = tcnt_r + 2'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tcnt_r == LAST_TICK_C) begin
                        // Leave at mid-stop so a following start edge is not missed.
                        deliver_s  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        frame_err_s = !rxs_s || par_err_r;
`else
                        frame_err_s = !rxs_s;
`endif
                        tcnt_nx_s  = 2'd0;
                        state_nx_s = ST_IDLE;
                    end else begin
                        tcnt_nx_s = tcnt_r + 2'd1;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    tcnt_nx_s  = 2'd0;
                    bcnt_nx_s  = 3'd0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Frame state, counters and shift register.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state_r   <= ST_IDLE;
            tcnt_r    <= 2'd0;
            bcnt_r    <= 3'd0;
            shift_r   <= 8'h00;
            rx_busy_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_nx_s;
            tcnt_r    <= tcnt_nx_s;
            bcnt_r    <= bcnt_nx_s;
            shift_r   <= shift_nx_s;
            rx_busy_r <= (state_nx_s != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            par_err_r <= par_err_nx_s;
`endif
        end
    end

    // Holding register and flags; a delivery coinciding with rx_ack takes precedence over the ack.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            parallel_out_r <= 8'h00;
            rx_ready_r     <= 1'b0;
            framing_err_r  <= 1'b0;
            overrun_r      <= 1'b0;
        end else if (deliver_s && (!rx_ready_r || bus.rx_ack)) begin
            parallel_out_r <= shift_r;
            rx_ready_r     <= 1'b1;
            framing_err_r  <= frame_err_s;
            overrun_r      <= bus.rx_ack ? 1'b0 : overrun_r;
        end else if (deliver_s) begin
            overrun_r <= 1'b1;
        end else if (bus.rx_ack) begin
            rx_ready_r    <= 1'b0;
            framing_err_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.parallel_out = parallel_out_r;
    assign bus.rx_ready     = rx_ready_r;
    assign bus.framing_err  = framing_err_r;
    assign bus.overrun      = overrun_r;
    assign bus.rx_busy      = rx_busy_r;

endmodule

// File: tb/tb_uart_v2_rx.sv
// tb_uart_v2_rx: directed and randomized frames against a frame-level model
// of the receiver's holding register. Define UART_RX_PARITY_EN for 8E1.
module tb_uart_v2_rx;

    logic sysclk;
    logic sysreset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] exp_byte;
    logic       exp_ready;
    logic       exp_ferr;
    logic       exp_ovr;
`ifdef UART_RX_PARITY_EN
    logic       frame_par;
`endif

    uart_v2_rx_if bus();

    uart_v2_rx dut (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .bus      (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // sample_en: one-cycle strobe every 11 sysclk cycles
    initial begin
        bus.sample_en = 1'b0;
        forever begin
            repeat (10) @(posedge sysclk);
            #1 bus.sample_en = 1'b1;
            @(posedge sysclk);
            #1 bus.sample_en = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".byte"},  bus.parallel_out, exp_byte);
        chk({tag, ".ready"}, {7'd0, bus.rx_ready},    {7'd0, exp_ready});
        chk({tag, ".ferr"},  {7'd0, bus.framing_err}, {7'd0, exp_ferr});
        chk({tag, ".ovr"},   {7'd0, bus.overrun},     {7'd0, exp_ovr});
    endtask

    // returns 2 time units after the sysclk edge that consumed a sample_en tick
    task automatic wait_tick();
        do @(posedge sysclk); while (bus.sample_en !== 1'b1);
        #2;
    endtask

    task automatic model_reset();
        exp_byte = 8'h00; exp_ready = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    endtask

    // Holding-register behaviour when a complete frame arrives.
    task automatic model_deliver(input logic [7:0] d, input logic ferr, input logic ack);
        if (!exp_ready || ack) begin
            exp_byte  = d;
            exp_ready = 1'b1;
            exp_ferr  = ferr;
            if (ack) exp_ovr = 1'b0;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    // One-cycle rx_ack while idle, then realign to a tick.
    task automatic do_ack(input string tag);
        bus.rx_ack = 1'b1;
        @(posedge sysclk);
        #2 bus.rx_ack = 1'b0;
        exp_ready = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        chk_all(tag);
        wait_tick();
    endtask

    // Drives one frame; called just after a tick with the receiver idle.
    // Tick 0 is the next tick; every line bit spans 4 ticks.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic stop_b, input logic ack_dlv);
        logic ferr;
        int   guard;
        bus.rx_line = 1'b0;
        repeat (4) wait_tick();
        chk({tag, ".busy"}, {7'd0, bus.rx_busy}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            bus.rx_line = d[i];
            repeat (4) wait_tick();
        end
        ferr = !stop_b;
`ifdef UART_RX_PARITY_EN
        bus.rx_line = frame_par;
        repeat (4) wait_tick();
        ferr = ferr || (frame_par != ^d);
`endif
        bus.rx_line = stop_b;
        repeat (2) wait_tick();
        chk({tag, ".pre_ready"}, {7'd0, bus.rx_ready}, {7'd0, exp_ready});
        if (ack_dlv) begin
            guard = 0;
            do begin
                @(posedge sysclk); #2;
                guard++;
            end while (bus.sample_en !== 1'b1 && guard < 40);
            if (guard >= 40) chk({tag, ".strobe_timeout"}, 8'd1, 8'd0);
            bus.rx_ack = 1'b1;
            @(posedge sysclk);
            #2 bus.rx_ack = 1'b0;
        end else begin
            wait_tick();
        end
        model_deliver(d, ferr, ack_dlv);
        chk_all(tag);
        chk({tag, ".idle"}, {7'd0, bus.rx_busy}, 8'd0);
        bus.rx_line = 1'b1;
        wait_tick();
    endtask

    initial begin
        logic [7:0] d;
        logic       sb;
        int         mode;

        sysreset    = 1'b0;
        bus.rx_line = 1'b1;
        bus.rx_ack  = 1'b0;
        model_reset();
`ifdef UART_RX_PARITY_EN
        frame_par = 1'b0;
`endif
        repeat (3) @(posedge sysclk);
        #2;
        chk_all("reset");
        chk("reset.busy", {7'd0, bus.rx_busy}, 8'd0);
        sysreset = 1'b1;
        repeat (2) wait_tick();

        // clean frame, rx_ready timing checked inside
`ifdef UART_RX_PARITY_EN
        frame_par = ^8'hA5;
`endif
        send_frame("a5", 8'hA5, 1'b1, 1'b0);
        do_ack("a5_ack");

        // one-tick low glitch while idle
        bus.rx_line = 1'b0;
        wait_tick();
        chk("glitch.t0_busy", {7'd0, bus.rx_busy}, 8'd1);
        bus.rx_line = 1'b1;
        wait_tick();
        chk("glitch.t1_busy", {7'd0, bus.rx_busy}, 8'd1);
        wait_tick();
        chk("glitch.t2_busy", {7'd0, bus.rx_busy}, 8'd0);
        chk("glitch.ready", {7'd0, bus.rx_ready}, 8'd0);
        wait_tick();

        // low stop bit
`ifdef UART_RX_PARITY_EN
        frame_par = ^8'h3C;
`endif
        send_frame("3c_stop_low", 8'h3C, 1'b0, 1'b0);
        do_ack("3c_ack");

        // back-to-back without ack -> overrun, first byte kept
`ifdef UART_RX_PARITY_EN
        frame_par = ^8'h11;
`endif
        send_frame("b2b_11", 8'h11, 1'b1, 1'b0);
`ifdef UART_RX_PARITY_EN
        frame_par = ^8'h22;
`endif
        send_frame("b2b_22", 8'h22, 1'b1, 1'b0);
        do_ack("b2b_ack");

        // back-to-back with ack in the delivery cycle of the second frame
`ifdef UART_RX_PARITY_EN
        frame_par = ^8'h11;
`endif
        send_frame("b2b_ack_11", 8'h11, 1'b1, 1'b0);
`ifdef UART_RX_PARITY_EN
        frame_par = ^8'h22;
`endif
        send_frame("b2b_ack_22", 8'h22, 1'b1, 1'b1);
        do_ack("b2b_ack2");

        // break-like frame: all zero with low stop
`ifdef UART_RX_PARITY_EN
        frame_par = 1'b0;
`endif
        send_frame("break", 8'h00, 1'b0, 1'b0);
        do_ack("break_ack");

        // randomized frames, stop bits and ack placement
        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom);
            sb   = ($urandom_range(0, 4) != 0);
            mode = $urandom_range(0, 2);
`ifdef UART_RX_PARITY_EN
            frame_par = (^d) ^ ($urandom_range(0, 4) == 0);
`endif
            send_frame("rand", d, sb, (mode == 1));
            if (mode == 2) do_ack("rand_ack");
            repeat ($urandom_range(0, 2)) wait_tick();
        end

        // make the outputs non-zero, then reset in the middle of a frame
`ifdef UART_RX_PARITY_EN
        frame_par = ^8'h5A;
`endif
        send_frame("pre_rst", 8'h5A, 1'b0, 1'b0);
        bus.rx_line = 1'b0;
        repeat (21) wait_tick();
        chk("midrst.busy_before", {7'd0, bus.rx_busy}, 8'd1);
        sysreset = 1'b0;
        #1;
        model_reset();
        chk_all("midrst");
        chk("midrst.busy", {7'd0, bus.rx_busy}, 8'd0);
        bus.rx_line = 1'b1;
        repeat (5) @(posedge sysclk);
        #2 sysreset = 1'b1;
        repeat (2) wait_tick();
`ifdef UART_RX_PARITY_EN
        frame_par = ^8'h7E;
`endif
        send_frame("after_rst_7e", 8'h7E, 1'b1, 1'b0);
        do_ack("7e_ack");

`ifdef UART_RX_PARITY_EN
        frame_par = 1'b0;
        send_frame("par_81_ok", 8'h81, 1'b1, 1'b0);
        do_ack("par_ok_ack");
        frame_par = 1'b1;
        send_frame("par_81_bad", 8'h81, 1'b1, 1'b0);
        do_ack("par_bad_ack");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_v2_rx.md
# uart_v2_rx

Asynchronous serial receiver that pairs with `uart_v2_tx`: 8N1 frames, LSB first, oversampled at 4x the bit rate. It runs in the MCU `sysclk` domain and uses a one-cycle `sample_en` strobe at 4x the bit rate instead of a second clock. A received byte is held in a single holding register with a ready/ack handshake, and is exposed to the MCU as one of the I/O registers.

## Interface
- `OVERSAMPLE`, 4: `sample_en` ticks per bit. Only 4 is supported.
- `sysclk` in 1: system clock.
- `sysreset` in 1: asynchronous, active-low reset.
- `sample_en` in 1: one-`sysclk` strobe at 4x the bit rate.
- `rx_line` in 1: serial input, idle high, asynchronous to `sysclk`.
- `parallel_out` out 8: received byte. Reset value 8'h00.
- `rx_ready` out 1: `parallel_out` holds an unread byte. Reset value 0.
- `rx_ack` in 1: one-`sysclk` read strobe from the MCU. Consumes the byte and clears both error flags.
- `framing_err` out 1: the byte currently held had a low stop bit. Reset value 0.
- `overrun` out 1: a complete frame was lost because the holding register was full. Sticky. Reset value 0.
- `rx_busy` out 1: the state machine is not in IDLE. Reset value 0.

## Operation
- `rx_line` passes through a 2-flop synchronizer whose flops reset to 1. All logic below uses the synchronized signal `rxs`.
- States: IDLE, START, DATA, (PARITY), STOP. A 2-bit tick counter `tcnt` and a 3-bit bit counter `bcnt` advance only on `sample_en`.
- **IDLE:** on a `sample_en` with `rxs`=0, go to START with `tcnt`=0.
- **START:** at the 2nd tick after entry (mid-bit), sample `rxs`.
  - `rxs`=1: false start. Return to IDLE; no flags change.
  - `rxs`=0: go to DATA with `tcnt`=0 and `bcnt`=0.
- **DATA:** every 4th tick, shift `rxs` into the MSB of the shift register (LSB first on the line). After `bcnt`=7, go to STOP (or PARITY when the parity macro is defined).
- **STOP:** at the 4th tick, sample `rxs`, deliver the frame to the holding register, and return to IDLE in that same cycle. Returning at mid-stop-bit lets back-to-back frames be received.
- **Delivery:** the `sysclk` edge after the stop sample.
  - If `rx_ready`=0, or `rx_ack`=1 in that cycle: load `parallel_out`, set `rx_ready`=1, and set `framing_err` = !stop_sample.
  - Otherwise: discard the new byte, keep the old byte and its flags, and set `overrun`=1.
- **`rx_ack`:**
  - Clears `rx_ready`, `framing_err` and `overrun`.
  - Ignored while `rx_ready`=0, except that it still clears `overrun`.
  - When `rx_ack` and delivery fall in the same cycle, delivery wins: `rx_ready` stays 1 with the new byte, and `overrun` is not set.
- **Break condition** (line held low): the frame is delivered as 8'h00 with `framing_err`=1. The machine then waits in IDLE until `rxs` is seen low on a tick. A line that stays low therefore produces one frame per 10 bit times, and each of those frames has `framing_err` set.
- **Reset mid-frame:** all state clears asynchronously. After release, the receiver sits in IDLE and resynchronizes on the next falling edge. It may also start on a line that is already low; a false start is rejected only if `rxs` is high at mid-start.

## Timing
- Tick numbering: tick 0 is the first tick that sees `rxs` low.
  - Mid-start sample: tick 2.
  - Data bit n is sampled at tick 6+4n; bit 7 at tick 34.
  - Stop bit sampled at tick 38 (tick 42 when parity is enabled).
- `rx_ready` rises one `sysclk` after the stop-sample tick.
- Synchronizer delay adds 2 `sysclk` cycles between the `rx_line` edge and `rxs`.
- Start-edge detection uncertainty is up to one tick period. The resulting worst-case sampling offset is ±¼ bit.
- `rx_ack` takes effect on the edge where it is sampled high. `rx_ready` reads low in the following cycle.

## Configuration
- `UART_RX_PARITY_EN`
  - **Defined:** 8E1 frames. A PARITY state is inserted after DATA and samples at tick 38; stop moves to tick 42. A parity mismatch sets `framing_err` exactly like a low stop bit. No separate port is added.
  - **Undefined:** 8N1. The PARITY state and its logic are absent.

## Structure
- `uart_v2_pkg` holds:
  - the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - `UART_OVERSAMPLE`=4;
  - `UART_MID_TICK`=2.
- `uart_v2_tx` uses the same package.
- One sub-module, `sync2`: the 2-flop synchronizer with a reset-value parameter, instantiated with reset value 1.

## Test plan
- Frame 8'hA5 8N1, `sample_en` every 11 `sysclk` cycles → `parallel_out`=8'hA5, `rx_ready`=1 exactly one cycle after tick 38, `framing_err`=0.
- Low glitch of 1 tick (bounded by the 2-cycle synchronizer) in IDLE → back to IDLE at tick 2, `rx_ready` stays 0, `rx_busy` pulses for 2 ticks only.
- Frame 8'h3C with stop bit low → `parallel_out`=8'h3C, `framing_err`=1; `rx_ack` clears both `rx_ready` and `framing_err`.
- Frames 8'h11 then 8'h22 back-to-back, no `rx_ack` → `parallel_out`=8'h11, `overrun`=1. Repeat with `rx_ack` in the delivery cycle of 8'h22 → `parallel_out`=8'h22, `rx_ready`=1, `overrun`=0.
- Reset asserted at tick 20 of a frame, released 5 cycles later, then frame 8'h7E → all outputs 0 during reset, then 8'h7E is received cleanly.
- With `UART_RX_PARITY_EN`: frame 8'h81 with parity bit 0 → `framing_err`=0. Same frame with parity bit 1 → `framing_err`=1 and `rx_ready` at tick 42+1.
